// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 panel monitor.
package hub75_pkg;

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } mon_state_e;

    // Width of the per-cycle increment fed to the saturating accumulators.
    localparam int SAT_INC_W = 1;

    function automatic int addr_w(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int col_w(input int width);
        return $clog2(width);
    endfunction

    function automatic int row_w(input int chains, input int rows);
        return $clog2(chains) + $clog2(rows);
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/hub75_panel_monitor_if.sv
// HUB75 bus as seen on the panel connector; the controller drives, the monitor listens.
interface hub75_panel_monitor_if #(
    parameter int CHAINS = 2,
    parameter int AW     = 4
);
    logic [CHAINS-1:0] hub75_red;
    logic [CHAINS-1:0] hub75_green;
    logic [CHAINS-1:0] hub75_blue;
    logic [AW-1:0]     hub75_addr;
    logic              hub75_clk;
    logic              hub75_latch;
    logic              hub75_oe;

    modport master (
        output hub75_red, hub75_green, hub75_blue,
        output hub75_addr, hub75_clk, hub75_latch, hub75_oe
    );

    modport slave (
        input hub75_red, hub75_green, hub75_blue,
        input hub75_addr, hub75_clk, hub75_latch, hub75_oe
    );
endinterface

// File: rtl/hub75_line_buffer.sv
// Column counter, shift register and latched line of the panel, with shift-count error flags.
module hub75_line_buffer
    import hub75_pkg::*;
#(
    parameter int PANEL_WIDTH = 64,
    parameter int CHAINS      = 2
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          i_shift,
    input  logic                          i_latch_hi,
    input  logic                          i_latch_rise,
    input  logic                          i_err_clear,
    input  logic [CHAINS-1:0]             i_red,
    input  logic [CHAINS-1:0]             i_green,
    input  logic [CHAINS-1:0]             i_blue,
    input  logic [col_w(PANEL_WIDTH)-1:0] i_probe_x,
    input  logic [$clog2(CHAINS)-1:0]     i_probe_chain,
    output logic [2:0]                    o_probe_rgb,
    output logic                          o_err_overflow,
    output logic                          o_err_short
);

    localparam int XW = col_w(PANEL_WIDTH);
    localparam int NW = cnt_w(PANEL_WIDTH);
    localparam logic [NW-1:0] FULL = NW'(PANEL_WIDTH);
    localparam logic [NW-1:0] ONE  = {{(NW-1){1'b0}}, 1'b1};

    logic [NW-1:0]     r_col_cnt;
    logic [NW-1:0]     w_base_cnt;
    logic [NW-1:0]     w_next_cnt;
    logic [XW-1:0]     w_wr_idx;
    logic              w_wr_en;
    logic              w_ovf_set;
    logic              w_short_set;
    logic [CHAINS-1:0] r_shift_red   [PANEL_WIDTH];
    logic [CHAINS-1:0] r_shift_green [PANEL_WIDTH];
    logic [CHAINS-1:0] r_shift_blue  [PANEL_WIDTH];
    logic [CHAINS-1:0] r_lat_red     [PANEL_WIDTH];
    logic [CHAINS-1:0] r_lat_green   [PANEL_WIDTH];
    logic [CHAINS-1:0] r_lat_blue    [PANEL_WIDTH];

    // Next column position; a shift coinciding with a latch edge starts the new line at x=0.
    always_comb begin
        w_base_cnt  = i_latch_rise ? {NW{1'b0}} : r_col_cnt;
        w_short_set = i_latch_rise & (r_col_cnt < FULL);
        w_wr_en     = 1'b0;
        w_ovf_set   = 1'b0;
        w_next_cnt  = w_base_cnt;
        if (i_shift) begin
            if (w_base_cnt < FULL) begin
                w_wr_en    = 1'b1;
                w_next_cnt = w_base_cnt + ONE;
            end else begin
                w_ovf_set  = 1'b1;
            end
        end else begin
            w_next_cnt = w_base_cnt;
        end
        w_wr_idx = w_base_cnt[XW-1:0];
    end

    // Column counter and shift register storage.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_col_cnt <= {NW{1'b0}};
            for (int i = 0; i < PANEL_WIDTH; i++) begin
                r_shift_red[i]   <= {CHAINS{1'b0}};
                r_shift_green[i] <= {CHAINS{1'b0}};
                r_shift_blue[i]  <= {CHAINS{1'b0}};
            end
        end else begin
            r_col_cnt <= w_next_cnt;
            if (w_wr_en) begin
                r_shift_red[w_wr_idx]   <= i_red;
                r_shift_green[w_wr_idx] <= i_green;
                r_shift_blue[w_wr_idx]  <= i_blue;
            end
        end
    end

    // Latched line is transparent to the shift register for every cycle latch is high.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < PANEL_WIDTH; i++) begin
                r_lat_red[i]   <= {CHAINS{1'b0}};
                r_lat_green[i] <= {CHAINS{1'b0}};
                r_lat_blue[i]  <= {CHAINS{1'b0}};
            end
        end else if (i_latch_hi) begin
            r_lat_red   <= r_shift_red;
            r_lat_green <= r_shift_green;
            r_lat_blue  <= r_shift_blue;
        end
    end

    // Sticky shift-count flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            o_err_overflow <= 1'b0;
            o_err_short    <= 1'b0;
        end else if (i_err_clear) begin
            o_err_overflow <= 1'b0;
            o_err_short    <= 1'b0;
        end else begin
            o_err_overflow <= o_err_overflow | w_ovf_set;
            o_err_short    <= o_err_short | w_short_set;
        end
    end

    // Probe read port: {blue, green, red} of one latched pixel.
    always_comb begin
        o_probe_rgb = {r_lat_blue[i_probe_x][i_probe_chain],
                       r_lat_green[i_probe_x][i_probe_chain],
                       r_lat_red[i_probe_x][i_probe_chain]};
    end

endmodule

// File: rtl/hub75_panel_monitor.sv
// HUB75 panel-side monitor: rebuilds the latched line and integrates probe-pixel on-time per frame.
// Optional latch-during-OE check is built when HUB75_MON_GHOST_CHECK_EN is defined.
module hub75_panel_monitor
    import hub75_pkg::*;
#(
    parameter int PANEL_WIDTH = 64,
    parameter int SCAN_ROWS   = 16,
    parameter int CHAINS      = 2,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                                  clk,
    input  logic                                  n_reset,
    hub75_panel_monitor_if.slave                  bus,
    input  logic [col_w(PANEL_WIDTH)-1:0]         probe_x,
    input  logic [row_w(CHAINS, SCAN_ROWS)-1:0]   probe_y,
    input  logic                                  err_clear,
    output logic                                  frame_done,
    output logic [ACC_WIDTH-1:0]                  frame_red,
    output logic [ACC_WIDTH-1:0]                  frame_green,
    output logic [ACC_WIDTH-1:0]                  frame_blue,
    output logic [ACC_WIDTH-1:0]                  frame_oe_cycles,
    output logic                                  err_overflow,
    output logic                                  err_short,
    output logic                                  err_addr_oe,
    output logic                                  err_latch_oe
);

    localparam int AW = addr_w(SCAN_ROWS);
    localparam int XW = col_w(PANEL_WIDTH);
    localparam int YW = row_w(CHAINS, SCAN_ROWS);
    localparam logic [AW-1:0] LAST_ROW = AW'(SCAN_ROWS - 1);

    function automatic logic [ACC_WIDTH-1:0] sat_inc(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [SAT_INC_W-1:0] inc);
        if (a == {ACC_WIDTH{1'b1}}) begin
            return a;
        end else begin
            return a + {{(ACC_WIDTH-SAT_INC_W){1'b0}}, inc};
        end
    endfunction

    logic [CHAINS-1:0]    r_red, r_green, r_blue;
    logic [AW-1:0]        r_addr, r_addr_d;
    logic                 r_clk, r_clk_d, r_latch, r_latch_d, r_oe, r_oe_d;
    mon_state_e           r_state, w_state_next;
    logic                 w_accumulate, w_frame_done_s, w_probe_load;
    logic [XW-1:0]        r_probe_x;
    logic [YW-1:0]        r_probe_y;
    logic [ACC_WIDTH-1:0] r_acc_red, r_acc_green, r_acc_blue, r_acc_oe;
    logic [ACC_WIDTH-1:0] w_acc_red_nxt, w_acc_green_nxt, w_acc_blue_nxt, w_acc_oe_nxt;
    logic [2:0]           w_probe_rgb;
    logic                 w_clk_rise, w_latch_rise, w_frame_end, w_oe_on, w_probe_hit;
    logic                 w_addr_oe_set;

    // Single input register stage plus one history stage for edge detection; OE idles deasserted.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_red     <= {CHAINS{1'b0}};
            r_green   <= {CHAINS{1'b0}};
            r_blue    <= {CHAINS{1'b0}};
            r_addr    <= {AW{1'b0}};
            r_addr_d  <= {AW{1'b0}};
            r_clk     <= 1'b0;
            r_clk_d   <= 1'b0;
            r_latch   <= 1'b0;
            r_latch_d <= 1'b0;
            r_oe      <= 1'b1;
            r_oe_d    <= 1'b1;
        end else begin
            r_red     <= bus.hub75_red;
            r_green   <= bus.hub75_green;
            r_blue    <= bus.hub75_blue;
            r_addr    <= bus.hub75_addr;
            r_addr_d  <= r_addr;
            r_clk     <= bus.hub75_clk;
            r_clk_d   <= r_clk;
            r_latch   <= bus.hub75_latch;
            r_latch_d <= r_latch;
            r_oe      <= bus.hub75_oe;
            r_oe_d    <= r_oe;
        end
    end

    assign w_clk_rise    = r_clk & ~r_clk_d;
    assign w_latch_rise  = r_latch & ~r_latch_d;
    assign w_frame_end   = (r_addr_d == LAST_ROW) && (r_addr == {AW{1'b0}});
    assign w_oe_on       = ~r_oe;
    assign w_probe_hit   = w_oe_on & (r_addr == r_probe_y[AW-1:0]);
    assign w_addr_oe_set = (r_addr != r_addr_d) & ~r_oe & ~r_oe_d;

    hub75_line_buffer #(
        .PANEL_WIDTH (PANEL_WIDTH),
        .CHAINS      (CHAINS)
    ) u_line_buffer (
        .clk            (clk),
        .n_reset        (n_reset),
        .i_shift        (w_clk_rise),
        .i_latch_hi     (r_latch),
        .i_latch_rise   (w_latch_rise),
        .i_err_clear    (err_clear),
        .i_red          (r_red),
        .i_green        (r_green),
        .i_blue         (r_blue),
        .i_probe_x      (r_probe_x),
        .i_probe_chain  (r_probe_y[YW-1:AW]),
        .o_probe_rgb    (w_probe_rgb),
        .o_err_overflow (err_overflow),
        .o_err_short    (err_short)
    );

    assign w_acc_oe_nxt    = sat_inc(r_acc_oe, w_oe_on);
    assign w_acc_red_nxt   = sat_inc(r_acc_red, w_probe_hit & w_probe_rgb[0]);
    assign w_acc_green_nxt = sat_inc(r_acc_green, w_probe_hit & w_probe_rgb[1]);
    assign w_acc_blue_nxt  = sat_inc(r_acc_blue, w_probe_hit & w_probe_rgb[2]);

    // Frame sync state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first wrap only arms the monitor; every later wrap closes a frame.
    always_comb begin
        w_state_next   = r_state;
        w_accumulate   = 1'b0;
        w_frame_done_s = 1'b0;
        w_probe_load   = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                if (w_frame_end) begin
                    w_state_next = ACCUM;
                    w_probe_load = 1'b1;
                end else begin
                    w_state_next = WAIT_SYNC;
                end
            end
            ACCUM: begin
                w_accumulate = 1'b1;
                if (w_frame_end) begin
                    w_frame_done_s = 1'b1;
                    w_probe_load   = 1'b1;
                end else begin
                    w_frame_done_s = 1'b0;
                end
            end
            default: begin
                w_state_next = WAIT_SYNC;
            end
        endcase
    end

    // Running accumulators; the wrap cycle still belongs to the frame being closed.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_acc_red   <= {ACC_WIDTH{1'b0}};
            r_acc_green <= {ACC_WIDTH{1'b0}};
            r_acc_blue  <= {ACC_WIDTH{1'b0}};
            r_acc_oe    <= {ACC_WIDTH{1'b0}};
        end else if (w_frame_done_s || !w_accumulate) begin
            r_acc_red   <= {ACC_WIDTH{1'b0}};
            r_acc_green <= {ACC_WIDTH{1'b0}};
            r_acc_blue  <= {ACC_WIDTH{1'b0}};
            r_acc_oe    <= {ACC_WIDTH{1'b0}};
        end else begin
            r_acc_red   <= w_acc_red_nxt;
            r_acc_green <= w_acc_green_nxt;
            r_acc_blue  <= w_acc_blue_nxt;
            r_acc_oe    <= w_acc_oe_nxt;
        end
    end

    // Frame result registers and done pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            frame_done      <= 1'b0;
            frame_red       <= {ACC_WIDTH{1'b0}};
            frame_green     <= {ACC_WIDTH{1'b0}};
            frame_blue      <= {ACC_WIDTH{1'b0}};
            frame_oe_cycles <= {ACC_WIDTH{1'b0}};
        end else begin
            frame_done <= w_frame_done_s;
            if (w_frame_done_s) begin
                frame_red       <= w_acc_red_nxt;
                frame_green     <= w_acc_green_nxt;
                frame_blue      <= w_acc_blue_nxt;
                frame_oe_cycles <= w_acc_oe_nxt;
            end
        end
    end

    // Probe coordinates are frozen for a whole frame so a mid-frame change cannot split counts.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_probe_x <= {XW{1'b0}};
            r_probe_y <= {YW{1'b0}};
        end else if (w_probe_load) begin
            r_probe_x <= probe_x;
            r_probe_y <= probe_y;
        end
    end

    // Sticky address-change-while-lit flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_addr_oe <= 1'b0;
        end else if (err_clear) begin
            err_addr_oe <= 1'b0;
        end else begin
            err_addr_oe <= err_addr_oe | w_addr_oe_set;
        end
    end

`ifdef HUB75_MON_GHOST_CHECK_EN
    // Sticky latch-while-lit flag (ghosting hazard).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            err_latch_oe <= 1'b0;
        end else if (err_clear) begin
            err_latch_oe <= 1'b0;
        end else begin
            err_latch_oe <= err_latch_oe | (r_latch & ~r_oe);
        end
    end
`else
    assign err_latch_oe = 1'b0;
`endif

endmodule

// File: doc/hub75_panel_monitor.md
Name: hub75_panel_monitor

Overview:
Synthesizable HUB75 panel-side monitor: samples the HUB75 bus driven by the controller, rebuilds the shifted and latched line, and integrates OE-on time for one selectable probe pixel across a frame. It also flags protocol violations. It is the parametrised successor of the fixed 64x32, 2-chain panel model, generalised in width, scan depth and chain count. It sits beside the controller in the FPGA image (loopback self-test) and in benches.

Parameters:
PANEL_WIDTH, 64, columns shifted per line (≥2)
SCAN_ROWS, 16, address rows; power of 2; AW = clog2(SCAN_ROWS)
CHAINS, 2, row groups driven in parallel (bits per colour bus); total rows = CHAINS*SCAN_ROWS
ACC_WIDTH, 24, probe accumulator width

Ports:
clk  in  1  system clock; HUB75 inputs are synchronous to it
n_reset  in  1  asynchronous, active-low reset
hub75_red  in  CHAINS  red bit per chain
hub75_green  in  CHAINS  green bit per chain
hub75_blue  in  CHAINS  blue bit per chain
hub75_addr  in  AW  row address
hub75_clk  in  1  shift clock (sampled; rising edge = shift)
hub75_latch  in  1  latch, active high
hub75_oe  in  1  output enable, active low
probe_x  in  clog2(PANEL_WIDTH)  probe column
probe_y  in  clog2(CHAINS)+AW  probe row; chain = upper bits, addr = low AW bits
err_clear  in  1  clears sticky error flags
frame_done  out  1  one-cycle pulse at frame end
frame_red / frame_green / frame_blue  out  ACC_WIDTH  probe on-cycles for the last complete frame
frame_oe_cycles  out  ACC_WIDTH  total OE-low cycles in the last frame
err_overflow  out  1  sticky: more than PANEL_WIDTH shifts before latch
err_short  out  1  sticky: latch rising with fewer than PANEL_WIDTH shifts
err_addr_oe  out  1  sticky: hub75_addr changed while OE asserted
err_latch_oe  out  1  sticky: latch asserted while OE asserted (optional feature)

Behaviour:
- Reset: all outputs 0; col_cnt=0; shift and latched buffers 0; state WAIT_SYNC; accumulators 0.
- Inputs registered once; edges are detected against the previous registered value. Total detection latency is 2 clk.
- Shift: on a detected hub75_clk rising edge, write the colour buses to shift[col_cnt], then col_cnt++. The first shifted pixel is x=0. col_cnt saturates at PANEL_WIDTH. A shift with col_cnt==PANEL_WIDTH sets err_overflow; its data is discarded.
- Latch: every cycle with latch high, latched ← shift. On the latch rising edge: if col_cnt<PANEL_WIDTH, set err_short; then col_cnt←0. A shift edge in the same cycle as the latch rising edge counts toward the new line.
- OE: each cycle with oe low (registered), frame_oe counter +1. If hub75_addr==probe_y[AW-1:0], add latched[probe_x][chain] per colour to the colour accumulators. All accumulators saturate at all-ones.
- err_addr_oe: addr register changes while oe is low in both the previous and current cycle.
- Frame end = addr transition from SCAN_ROWS-1 to 0.
- FSM:
  - WAIT_SYNC: accumulators held 0. Frame end → ACCUM, no pulse.
  - ACCUM: accumulate. Frame end → frame_done=1 for 1 cycle. The frame_* outputs load the accumulator values, including the current cycle's contribution. Accumulators clear. probe_x/probe_y are sampled here and held for the next frame; the initial probe is sampled on the WAIT_SYNC→ACCUM transition. Stays in ACCUM.
- err_clear has priority over a same-cycle error set. Flags are not cleared by frame end.
- Reset mid-frame returns to WAIT_SYNC; the first partial frame is never reported.

Optional Feature:
HUB75_MON_GHOST_CHECK_EN:
- Defined: err_latch_oe sets when registered latch=1 and oe=0 in the same cycle; cleared by err_clear.
- Undefined: no logic generated; err_latch_oe tied 0.

Decomposition:
- Package hub75_pkg:
  - width functions (clog2-based AW, XW, YW)
  - state typedef {WAIT_SYNC, ACCUM}
  - saturating-add width constant
- Sub-module hub75_line_buffer: input column counter, shift array, latched array, err_overflow/err_short generation. Exposes a probe read mux: (x, chain) → 3 bits.

Test Plan:
1. Defaults. Shift 64 pixels with pixel 5 = R on chain 1, latch, addr 3, oe low 10 cycles, complete wrap 15→0 twice; probe (5, 19) → frame_red=10, green=blue=0, frame_done exactly once per wrap after the first.
2. Shift 63 pixels then latch → err_short=1; then 65 shifts → err_overflow=1; err_clear pulse → both 0.
3. Change addr 2→3 while oe held low → err_addr_oe=1; same change with oe high → no flag.
4. Pulse n_reset mid-frame: outputs 0 immediately. First wrap after reset gives no frame_done; second wrap gives frame_done with that frame's counts only.
5. ACC_WIDTH=4, oe low 20 cycles on a lit probe pixel → frame_red=15 (saturated), frame_oe_cycles=15.
6. With HUB75_MON_GHOST_CHECK_EN: latch high during oe low → err_latch_oe=1. Without the macro: same stimulus → err_latch_oe=0.
